// File: rtl/snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl
//
// Purpose:
//   Converts the four debounced key pulses into the snake's movement
//   direction. It also generates the periodic move tick that paces the game
//   engine. Up to two pending turns are buffered between ticks. A turn that
//   would reverse the snake by 180 degrees, or repeat the direction it would
//   already be travelling, is rejected.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   run        game running (0 = paused / game over)
//   key_left   one-cycle press pulse
//   key_right  one-cycle press pulse
//   key_up     one-cycle press pulse
//   key_down   one-cycle press pulse
//   dir        current direction: 00 up, 01 down, 10 left, 11 right
//   move_tick  one-cycle step strobe
//   q_count    number of pending turns (0..2)
//   key_drop   one-cycle pulse when a decoded key is rejected
// -----------------------------------------------------------------------------
module snake_dir_ctrl #(
  parameter int STEP_CYCLES = 5_000_000,
  parameter int CNT_W       = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  output logic [1:0] dir,
  output logic       move_tick,
  output logic [1:0] q_count,
  output logic       key_drop
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic [CNT_W-1:0] cnt;

  // Two-entry turn queue: q0 is the head (next to be applied), q1 the second.
  logic [1:0] q0;
  logic [1:0] q1;

  logic       key_valid;
  logic [1:0] key_dir;
  logic [1:0] tail;
  logic       step_due;
  logic       pop;
  logic       reject;
  logic       accept;

  // Fixed-priority key decode; lower-priority keys in the same cycle are
  // simply discarded and never count as a rejection.
  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_UP;
    if (key_up)
      key_dir = DIR_UP;
    else if (key_down)
      key_dir = DIR_DOWN;
    else if (key_left)
      key_dir = DIR_LEFT;
    else if (key_right)
      key_dir = DIR_RIGHT;
    else
      key_valid = 1'b0;
  end

  // A new key is judged against the direction the snake will have after all
  // already-queued turns, i.e. the newest queue entry, or dir if empty.
  // The full-queue check is waived when a pop on this same edge frees a slot.
  always_comb begin
    case (q_count)
      2'd0:    tail = dir;
      2'd1:    tail = q0;
      default: tail = q1;
    endcase
    step_due = run && (cnt == LAST);
    pop      = step_due && (q_count != 2'd0);
    reject   = key_valid &&
               ((key_dir == tail) ||
                (key_dir == {tail[1], ~tail[0]}) ||
                ((q_count == 2'd2) && !pop));
    accept   = key_valid && !reject;
  end

  // Step counter, tick, direction update and turn queue. Pausing flushes
  // the queue and restarts the step period but keeps the current direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      move_tick <= 1'b0;
      dir       <= DIR_RIGHT;
      q_count   <= 2'd0;
      key_drop  <= 1'b0;
      q0        <= DIR_UP;
      q1        <= DIR_UP;
    end else if (!run) begin
      cnt       <= '0;
      move_tick <= 1'b0;
      key_drop  <= 1'b0;
      q_count   <= 2'd0;
    end else begin
      move_tick <= step_due;
      cnt       <= step_due ? '0 : cnt + 1'b1;
      key_drop  <= reject;
      if (pop)
        dir <= q0;
      case ({pop, accept})
        2'b11: begin
          // Pop and push together: occupancy unchanged, order preserved.
          if (q_count == 2'd1) begin
            q0 <= key_dir;
          end else begin
            q0 <= q1;
            q1 <= key_dir;
          end
        end
        2'b10: begin
          q0      <= q1;
          q_count <= q_count - 2'd1;
        end
        2'b01: begin
          if (q_count == 2'd0)
            q0 <= key_dir;
          else
            q1 <= key_dir;
          q_count <= q_count + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_dir_ctrl
//
// Purpose:
//   Self-checking bench for snake_dir_ctrl with STEP_CYCLES=8. A behavioural
//   model (integer step counter plus a SystemVerilog queue of pending turns)
//   is updated on every rising edge. A compare process checks all outputs
//   against it shortly after each edge. Directed scenarios add literal
//   expectations, and a randomized phase follows.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_snake_dir_ctrl;

  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic [1:0] dir;
  logic       move_tick;
  logic [1:0] q_count;
  logic       key_drop;

  int vectors = 0;
  int miscompares = 0;

  snake_dir_ctrl #(.STEP_CYCLES(STEP), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .key_left  (key_left),
    .key_right (key_right),
    .key_up    (key_up),
    .key_down  (key_down),
    .dir       (dir),
    .move_tick (move_tick),
    .q_count   (q_count),
    .key_drop  (key_drop)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic       m_valid = 1'b0;
  int         m_cnt;
  logic [1:0] m_dir;
  logic       m_tick;
  logic       m_drop;
  logic [1:0] m_q[$];
  logic [3:0] m_keys;
  logic       m_has;
  logic [1:0] m_key;
  logic [1:0] m_tail;
  logic       m_fire;
  logic       m_pop;

  // Model: keys indexed by their direction code, lowest code wins; a key is
  // compared with the direction after all queued turns.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_cnt   = 0;
      m_dir   = 2'b11;
      m_tick  = 1'b0;
      m_drop  = 1'b0;
      m_q.delete();
    end else if (!run) begin
      m_cnt  = 0;
      m_tick = 1'b0;
      m_drop = 1'b0;
      m_q.delete();
    end else begin
      m_keys = {key_right, key_left, key_down, key_up};
      m_has  = 1'b0;
      m_key  = 2'b00;
      for (int i = 3; i >= 0; i--) begin
        if (m_keys[i]) begin
          m_has = 1'b1;
          m_key = 2'(i);
        end
      end
      m_tail = (m_q.size() > 0) ? m_q[$] : m_dir;
      m_fire = (m_cnt == STEP - 1);
      m_pop  = m_fire && (m_q.size() > 0);
      m_drop = m_has && ((m_key == m_tail) ||
                         (m_key == {m_tail[1], ~m_tail[0]}) ||
                         (m_q.size() == 2 && !m_pop));
      if (m_pop)
        m_dir = m_q.pop_front();
      if (m_has && !m_drop)
        m_q.push_back(m_key);
      m_cnt  = m_fire ? 0 : m_cnt + 1;
      m_tick = m_fire;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      checkOutput("cyc_dir", int'(dir), int'(m_dir));
      checkOutput("cyc_tick", int'(move_tick), int'(m_tick));
      checkOutput("cyc_qcount", int'(q_count), m_q.size());
      checkOutput("cyc_drop", int'(key_drop), int'(m_drop));
    end
  end

  // Drives one set of key inputs for a single cycle.
  task automatic applyStimulus(input logic u, input logic d, input logic l, input logic r);
    key_up    = u;
    key_down  = d;
    key_left  = l;
    key_right = r;
    @(negedge clk);
    key_up    = 1'b0;
    key_down  = 1'b0;
    key_left  = 1'b0;
    key_right = 1'b0;
  endtask

  // Pulses the key with direction code 'code' and checks the response.
  task automatic pulseKey(input string name, input int code, input int exp_drop, input int exp_q);
    applyStimulus(code == 0, code == 1, code == 2, code == 3);
    checkOutput({name, "_drop"}, int'(key_drop), exp_drop);
    checkOutput({name, "_q"}, int'(q_count), exp_q);
  endtask

  task automatic waitTick(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!move_tick && n < 3 * STEP) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_seen"}, int'(move_tick), 1);
  endtask

  task automatic waitModelCnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 3 * STEP) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_cnt", m_cnt, target);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticks;

    // Reset state and free-running ticks with no keys.
    doReset();
    checkOutput("rst_dir", int'(dir), 3);
    checkOutput("rst_tick", int'(move_tick), 0);
    checkOutput("rst_q", int'(q_count), 0);
    checkOutput("rst_drop", int'(key_drop), 0);
    run = 1'b1;
    repeat (STEP - 1) @(negedge clk);
    checkOutput("tick_early", int'(move_tick), 0);
    @(negedge clk);
    checkOutput("tick8", int'(move_tick), 1);
    checkOutput("tick8_model", int'(m_tick), 1);
    repeat (STEP) @(negedge clk);
    checkOutput("tick16", int'(move_tick), 1);
    repeat (STEP) @(negedge clk);
    checkOutput("tick24", int'(move_tick), 1);
    checkOutput("tick24_dir", int'(dir), 3);

    // Single turn up applied on the next tick.
    doReset();
    run = 1'b1;
    repeat (3) @(negedge clk);
    pulseKey("up1", 0, 0, 1);
    waitTick("up1_tick");
    checkOutput("up1_dir", int'(dir), 0);
    checkOutput("up1_dir_model", int'(m_dir), 0);
    checkOutput("up1_q", int'(q_count), 0);

    // Reversal and repeat are rejected.
    doReset();
    run = 1'b1;
    pulseKey("rev_left", 2, 1, 0);
    @(negedge clk);
    pulseKey("same_right", 3, 1, 0);
    checkOutput("rev_dir", int'(dir), 3);

    // Queue fills, third key dropped, then two ticks drain.
    doReset();
    run = 1'b1;
    pulseKey("fill_up", 0, 0, 1);
    pulseKey("fill_left", 2, 0, 2);
    pulseKey("fill_down", 1, 1, 2);
    waitTick("fill_t1");
    checkOutput("fill_t1_dir", int'(dir), 0);
    checkOutput("fill_t1_q", int'(q_count), 1);
    waitTick("fill_t2");
    checkOutput("fill_t2_dir", int'(dir), 2);
    checkOutput("fill_t2_q", int'(q_count), 0);

    // Push into a full queue on the tick edge.
    doReset();
    run = 1'b1;
    pulseKey("sim_up", 0, 0, 1);
    pulseKey("sim_left", 2, 0, 2);
    waitModelCnt(STEP - 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_tick", int'(move_tick), 1);
    checkOutput("sim_dir", int'(dir), 0);
    checkOutput("sim_q", int'(q_count), 2);
    checkOutput("sim_drop", int'(key_drop), 0);
    waitTick("sim_t2");
    checkOutput("sim_t2_dir", int'(dir), 2);
    waitTick("sim_t3");
    checkOutput("sim_t3_dir", int'(dir), 1);
    checkOutput("sim_t3_dir_model", int'(m_dir), 1);

    // Pause flushes the queue and ignores keys; reset beats a pending tick.
    doReset();
    run = 1'b1;
    pulseKey("pause_up", 0, 0, 1);
    pulseKey("pause_left", 2, 0, 2);
    run = 1'b0;
    @(negedge clk);
    checkOutput("pause_q", int'(q_count), 0);
    checkOutput("pause_dir", int'(dir), 3);
    pulseKey("pause_key", 1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 3 * STEP; i++) begin
      @(negedge clk);
      if (move_tick)
        ticks++;
    end
    checkOutput("pause_ticks", ticks, 0);
    run = 1'b1;
    pulseKey("rst_up", 0, 0, 1);
    waitModelCnt(STEP - 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_tick", int'(move_tick), 0);
    checkOutput("midrst_dir", int'(dir), 3);
    checkOutput("midrst_q", int'(q_count), 0);

    // Randomized phase: the per-cycle compare does the checking.
    run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      run       = ($urandom_range(0, 59) != 0);
      key_up    = ($urandom_range(0, 5) == 0);
      key_down  = ($urandom_range(0, 5) == 0);
      key_left  = ($urandom_range(0, 5) == 0);
      key_right = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    key_up = 1'b0;
    key_down = 1'b0;
    key_left = 1'b0;
    key_right = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
